// File: rtl/wave_cap_pkg.sv
// Shared types and helpers for the oscilloscope capture write path.
package wave_cap_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE_FILL  = 3'd1,
    WAIT_TRIG = 3'd2,
    POST_FILL = 3'd3,
    DONE      = 3'd4
  } cap_state_t;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // (a - b) mod 2^aw; the buffer depth is always a power of two.
  function automatic logic [31:0] wrap_sub(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned aw);
    return (a - b) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/wave_cap_writer_if.sv
// Sample stream in and RAM write port out, bundled for the capture writer.
interface wave_cap_writer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  // sample_valid is a valid-only stream with no backpressure: a sample is
  // taken on any rising clk where sample_valid=1 and the writer is capturing.
  // wr_en is a one-cycle write strobe qualifying wr_addr/wr_data.
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  sample_valid, sample_data,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output sample_valid, sample_data,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/wave_trig_detect.sv
// Level-crossing trigger detector: holds the previous accepted sample and
// flags a rising or falling crossing of the threshold on the current sample.
module wave_trig_detect
  import wave_cap_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              accept,
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] level,
  input  logic              trig_edge,
  output logic              trig_hit
);

  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              cur_above;
  logic              prev_above;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clr) begin
      prev_valid <= 1'b0;
    end else if (accept) begin
      prev       <= cur;
      prev_valid <= 1'b1;
    end
  end

  always_comb begin
    cur_above  = (cur >= level);
    prev_above = (prev >= level);
    trig_hit   = 1'b0;
    if (prev_valid) begin
      if (trig_edge == EDGE_RISE) trig_hit = !prev_above && cur_above;
      else                        trig_hit = prev_above && !cur_above;
    end
  end

endmodule

// File: rtl/wave_cap_writer.sv
// Circular capture writer with pre-trigger history and post-trigger fill.
// Optional forced trigger after a timeout: define WAVE_CAP_AUTO_TRIG_EN.
module wave_cap_writer
  import wave_cap_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int PRE_DEPTH    = 256,
  parameter int AUTO_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  wave_cap_writer_if.master bus,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  output logic              busy,
  output logic              capture_done,
  output logic [ADDR_W-1:0] rd_start_addr,
  output logic [ADDR_W-1:0] trig_addr,
`ifdef WAVE_CAP_AUTO_TRIG_EN
  output logic              auto_trig,
`endif
  output cap_state_t        state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int POST  = DEPTH - PRE_DEPTH;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_DEPTH - 1);
  localparam logic [ADDR_W:0]   POST_LAST = (ADDR_W + 1)'(POST - 1);

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W:0]   post_cnt;
  logic              accept;
  logic              start;
  logic              trig_hit;
  logic              forced;
  logic              fire;

  assign accept = bus.sample_valid &&
                  (state == PRE_FILL || state == WAIT_TRIG || state == POST_FILL);
  assign start  = arm && (state == IDLE || state == DONE);
  assign fire   = accept && (state == WAIT_TRIG) && (trig_hit || forced);

  wave_trig_detect #(.DATA_W(DATA_W)) u_trig (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .accept    (accept),
    .cur       (bus.sample_data),
    .level     (trig_level),
    .trig_edge (trig_edge),
    .trig_hit  (trig_hit)
  );

`ifdef WAVE_CAP_AUTO_TRIG_EN
  logic [31:0] to_cnt;
  logic        auto_pend;
  assign forced = (to_cnt == 32'(AUTO_TIMEOUT));
`else
  assign forced = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      busy          <= 1'b0;
      capture_done  <= 1'b0;
      rd_start_addr <= '0;
      trig_addr     <= '0;
      ptr           <= '0;
      pre_cnt       <= '0;
      post_cnt      <= '0;
`ifdef WAVE_CAP_AUTO_TRIG_EN
      to_cnt        <= '0;
      auto_pend     <= 1'b0;
      auto_trig     <= 1'b0;
`endif
    end else begin
      bus.wr_en <= accept;
      if (accept) begin
        bus.wr_addr <= ptr;
        bus.wr_data <= bus.sample_data;
        ptr         <= ptr + 1'b1;
      end

      // DONE restarts exactly like IDLE; only capture_done needs clearing.
      if (start) begin
        ptr          <= '0;
        pre_cnt      <= '0;
        busy         <= 1'b1;
        capture_done <= 1'b0;
        state        <= PRE_FILL;
`ifdef WAVE_CAP_AUTO_TRIG_EN
        auto_pend    <= 1'b0;
        auto_trig    <= 1'b0;
`endif
      end

      case (state)
        PRE_FILL: begin
          if (accept) begin
            pre_cnt <= pre_cnt + 1'b1;
            if (pre_cnt == PRE_LAST) begin
              state <= WAIT_TRIG;
`ifdef WAVE_CAP_AUTO_TRIG_EN
              to_cnt <= '0;
`endif
            end
          end
        end
        WAIT_TRIG: begin
`ifdef WAVE_CAP_AUTO_TRIG_EN
          if (!forced) to_cnt <= to_cnt + 32'd1;
`endif
          if (fire) begin
            trig_addr     <= ptr;
            rd_start_addr <= ADDR_W'(wrap_sub(32'(ptr), 32'(PRE_DEPTH), ADDR_W));
            post_cnt      <= (ADDR_W + 1)'(1);
`ifdef WAVE_CAP_AUTO_TRIG_EN
            auto_pend     <= !trig_hit;
`endif
            // With a single post sample the trigger sample completes the frame.
            if (POST == 1) begin
              state        <= DONE;
              busy         <= 1'b0;
              capture_done <= 1'b1;
`ifdef WAVE_CAP_AUTO_TRIG_EN
              auto_trig    <= !trig_hit;
`endif
            end else begin
              state <= POST_FILL;
            end
          end
        end
        POST_FILL: begin
          if (accept) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt == POST_LAST) begin
              state        <= DONE;
              busy         <= 1'b0;
              capture_done <= 1'b1;
`ifdef WAVE_CAP_AUTO_TRIG_EN
              auto_trig    <= auto_pend;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_cap_writer.sv
// Directed bench for wave_cap_writer (DEPTH=16, PRE_DEPTH=4, POST=12);
// expected RAM writes are queued by the stimulus and checked by a monitor.
module tb_wave_cap_writer;
  import wave_cap_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int PRE_DEPTH = 4;
  localparam int AUTO_TIMEOUT = 20;
  localparam int EW = 1 + ADDR_W + DATA_W;

  logic              clk;
  logic              rst_n;
  logic              arm;
  logic [DATA_W-1:0] trig_level;
  logic              trig_edge;
  logic              busy;
  logic              capture_done;
  logic [ADDR_W-1:0] rd_start_addr;
  logic [ADDR_W-1:0] trig_addr;
  cap_state_t        state;
`ifdef WAVE_CAP_AUTO_TRIG_EN
  logic              auto_trig;
`endif

  wave_cap_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wave_cap_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .PRE_DEPTH(PRE_DEPTH), .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arm           (arm),
    .bus           (bus),
    .trig_level    (trig_level),
    .trig_edge     (trig_edge),
    .busy          (busy),
    .capture_done  (capture_done),
    .rd_start_addr (rd_start_addr),
    .trig_addr     (trig_addr),
`ifdef WAVE_CAP_AUTO_TRIG_EN
    .auto_trig     (auto_trig),
`endif
    .state         (state)
  );

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int wr_count = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard monitor: every write strobe must match the queue head
  always @(negedge clk) begin
    if (rst_n && bus.wr_en) begin
      logic [EW-1:0] e;
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%0d data=%0h done=%0b",
                 bus.wr_addr, bus.wr_data, capture_done);
      end else begin
        e = exp_q.pop_front();
        if ({capture_done, bus.wr_addr, bus.wr_data} !== e) begin
          failures++;
          $display("FAIL write got done=%0b addr=%0d data=%0h want done=%0b addr=%0d data=%0h",
                   capture_done, bus.wr_addr, bus.wr_data,
                   e[EW-1], e[EW-2:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int addr, input int data, input bit done);
    exp_q.push_back({done, ADDR_W'(addr), DATA_W'(data)});
  endtask

  task automatic send(input int data);
    bus.sample_valid = 1'b1;
    bus.sample_data  = DATA_W'(data);
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_frame(input string name, input int t_addr, input int r_addr, input int pulses);
    chk({name, "_done"}, 32'(capture_done), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_state"}, 32'(state), 32'(DONE));
    chk({name, "_trig_addr"}, 32'(trig_addr), 32'(t_addr));
    chk({name, "_rd_start"}, 32'(rd_start_addr), 32'(r_addr));
    chk({name, "_pulses"}, 32'(wr_count), 32'(pulses));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    chk({name, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({name, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(capture_done), 32'd0);
    chk({name, "_rd_start"}, 32'(rd_start_addr), 32'd0);
    chk({name, "_trig_addr"}, 32'(trig_addr), 32'd0);
    chk({name, "_state"}, 32'(state), 32'(IDLE));
  endtask

  initial begin
    rst_n = 1'b0;
    arm = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data = '0;
    trig_level = '0;
    trig_edge = EDGE_RISE;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_init");
    rst_n = 1'b1;
    idle_cycle();

    // rising trigger on a ramp: trigger at sample 10, frame ends at addr 5
    trig_level = 8'd10; trig_edge = EDGE_RISE; wr_count = 0;
    pulse_arm();
    chk("rise_busy_after_arm", 32'(busy), 32'd1);
    for (int i = 0; i < 22; i++) push(i % 16, i, i == 21);
    for (int i = 0; i < 25; i++) send(i);
    wait_drain("rise");
    chk_frame("rise", 10, 6, 22);

    // crossing at sample 2 lands in pre-fill; wrapped ramp triggers at 18
    trig_level = 8'd2; wr_count = 0;
    pulse_arm();
    chk("rearm_done_low", 32'(capture_done), 32'd0);
    chk("rearm_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 30; i++) push(i % 16, i % 16, i == 29);
    for (int i = 0; i < 32; i++) send(i % 16);
    wait_drain("premask");
    chk_frame("premask", 2, 14, 30);

    // falling trigger: 0xFF x6 then 0x10 triggers at addr 6
    trig_level = 8'h80; trig_edge = EDGE_FALL; wr_count = 0;
    pulse_arm();
    for (int i = 0; i < 6; i++) push(i, 8'hFF, 1'b0);
    for (int i = 6; i < 18; i++) push(i % 16, 8'h10, i == 17);
    for (int i = 0; i < 6; i++) send(8'hFF);
    for (int i = 0; i < 13; i++) send(8'h10);
    wait_drain("fall");
    chk_frame("fall", 6, 2, 18);

    // half-rate stream with a stray arm in WAIT_TRIG
    trig_level = 8'd10; trig_edge = EDGE_RISE; wr_count = 0;
    pulse_arm();
    for (int i = 0; i < 22; i++) push(i % 16, i, i == 21);
    for (int i = 0; i < 22; i++) begin
      send(i);
      if (i == 6) begin
        chk("stall_state_wait", 32'(state), 32'(WAIT_TRIG));
        pulse_arm();
      end else begin
        idle_cycle();
      end
    end
    wait_drain("stall");
    chk_frame("stall", 10, 6, 22);

    // arm from DONE restarts at addr 0, then reset mid post-fill
    pulse_arm();
    chk("done_arm_clears", 32'(capture_done), 32'd0);
    push(0, 8'h55, 1'b0);
    push(1, 1, 1'b0); push(2, 2, 1'b0); push(3, 3, 1'b0);
    push(4, 9, 1'b0); push(5, 10, 1'b0);
    push(6, 11, 1'b0); push(7, 12, 1'b0); push(8, 13, 1'b0);
    send(8'h55); send(1); send(2); send(3); send(9); send(10);
    send(11); send(12); send(13);
    wait_drain("restart");
    chk("restart_state_post", 32'(state), 32'(POST_FILL));
    chk("restart_trig_addr", 32'(trig_addr), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("reset_async");
    #3 rst_n = 1'b1;
    wr_count = 0;
    bus.sample_valid = 1'b1;
    bus.sample_data = 8'h33;
    repeat (5) @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    chk("post_reset_no_writes", 32'(wr_count), 32'd0);
    chk("post_reset_state", 32'(state), 32'(IDLE));

`ifdef WAVE_CAP_AUTO_TRIG_EN
    // constant input never crosses; forced trigger takes sample 24 (addr 8)
    trig_level = 8'h80; trig_edge = EDGE_RISE; wr_count = 0;
    pulse_arm();
    for (int i = 0; i < 36; i++) push(i % 16, 8'h40, i == 35);
    for (int i = 0; i < 38; i++) send(8'h40);
    wait_drain("auto");
    chk_frame("auto", 8, 4, 36);
    chk("auto_trig_flag", 32'(auto_trig), 32'd1);
    pulse_arm();
    chk("auto_trig_cleared", 32'(auto_trig), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_cap_writer.md
Name: wave_cap_writer

Overview:
Write-side controller for the oscilloscope sample buffer. It accepts an ADC sample stream and writes it circularly into the write port of a simple dual-port RAM. It detects a level/edge trigger, keeps a fixed pre-trigger history, and fills the post-trigger region. It then flags completion and reports the oldest-sample address to the display-side reader, which pulls the buffer through the RAM read port.

Parameters:
- ADDR_W, 10, RAM address width; buffer depth is DEPTH = 2^ADDR_W.
- DATA_W, 8, sample width in bits.
- PRE_DEPTH, 256, number of pre-trigger samples kept; legal range 1..DEPTH-1.
- AUTO_TIMEOUT, 1000000, clk cycles spent in WAIT_TRIG before a forced trigger (used only with the optional feature).

Ports:
- clk  in  1  system clock; every flop is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  single-cycle pulse; starts a capture.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  DATA_W  ADC sample, unsigned.
- trig_level  in  DATA_W  trigger threshold, unsigned.
- trig_edge  in  1  0 = rising edge, 1 = falling edge.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- busy  out  1  high while a capture is in progress.
- capture_done  out  1  buffer frozen and ready for the reader.
- rd_start_addr  out  ADDR_W  address of the oldest sample in the frame.
- trig_addr  out  ADDR_W  address of the trigger sample.

Behaviour:
- Reset: state = IDLE. wr_en, wr_addr, wr_data, busy, capture_done, rd_start_addr and trig_addr are all 0. The internal write pointer, counters and prev-sample-valid flag are cleared.
- Reset asserted mid-capture aborts the capture immediately; the partially written RAM contents are don't-care.
- POST = DEPTH - PRE_DEPTH, and the count includes the trigger sample.
- A sample is accepted when sample_valid=1 and the state is PRE_FILL, WAIT_TRIG or POST_FILL.
- Write latency:
  - An accepted sample appears on wr_en/wr_addr/wr_data on the next cycle.
  - wr_en is a 1-cycle pulse per accepted sample.
  - The write pointer increments per accepted sample and wraps DEPTH-1 -> 0.
- States:
  - IDLE: busy=0. On arm: pointer <- 0, pre count <- 0, prev-sample-valid <- 0, go to PRE_FILL.
  - PRE_FILL: busy=1. After PRE_DEPTH samples have been accepted, go to WAIT_TRIG. Triggers are ignored in this state, but the prev-sample register still updates.
  - WAIT_TRIG: busy=1. Writing continues circularly, overwriting old samples.
    - Rising trigger: prev < trig_level and cur >= trig_level.
    - Falling trigger: prev >= trig_level and cur < trig_level.
    - The trigger sample itself is written. trig_addr <- its address. rd_start_addr <- (its address - PRE_DEPTH) mod DEPTH. The post count starts at 1. Go to POST_FILL.
  - POST_FILL: busy=1, triggers are ignored. When the accepted sample brings the post count to POST, go to DONE. capture_done rises in the same cycle as that sample's wr_en pulse.
  - DONE: busy=0, capture_done=1, nothing is written. An arm pulse clears capture_done on the next cycle and restarts exactly as from IDLE.
- Edge comparison needs a valid previous sample. The first sample accepted after arm never triggers.
- arm is ignored in PRE_FILL, WAIT_TRIG and POST_FILL.
- trig_level and trig_edge are sampled continuously; software changes them only while IDLE or DONE.
- sample_valid gaps simply stall the pointer and counters; there is no timeout on input data.

Optional Feature:
- Macro: WAVE_CAP_AUTO_TRIG_EN.
- Defined:
  - A cycle counter runs in WAIT_TRIG and clears on entry to that state.
  - When it reaches AUTO_TIMEOUT, the next accepted sample is treated as the trigger sample, with the same address bookkeeping as a real trigger.
  - An extra output auto_trig (1 bit) is set together with capture_done and cleared on arm or reset.
- Undefined: no counter and no auto_trig port; WAIT_TRIG is held until a real trigger.

Decomposition:
- Package wave_cap_pkg holds:
  - state enum {IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, DONE};
  - edge constants EDGE_RISE=0, EDGE_FALL=1;
  - a function for the modulo start-address subtraction.
- One sub-module, wave_trig_detect: owns the prev-sample register and prev-valid flag, and produces a combinational trig_hit for the current sample. It is reused later by the roll/auto-scope path.

Test Plan (ADDR_W=4, PRE_DEPTH=4, DATA_W=8, so DEPTH=16 and POST=12):
- Reset values: assert rst_n=0 mid-POST_FILL -> all outputs 0 within the same cycle (async). Release rst_n -> IDLE, and no wr_en until arm.
- Rising trigger: trig_level=10, trig_edge=0, arm, then ramp 0,1,2,... with sample_valid=1 every cycle.
  - Writes go to addr = value.
  - Trigger on sample 10: trig_addr=10, rd_start_addr=6.
  - Last write is addr 5 with data 21; capture_done=1 in that cycle; exactly 22 wr_en pulses in total.
- Pre-fill masking: level=2 with ramp 0..; the crossing at sample 2 falls inside PRE_FILL and is ignored. Buffer wraps, and the next qualifying crossing triggers.
- Falling trigger: trig_edge=1, level=0x80, samples 0xFF x6 then 0x10 -> trig_addr=6, rd_start_addr=2.
- Stalls and arm handling:
  - Toggle sample_valid every other cycle -> same addresses and data as the rising-trigger case, at half rate.
  - arm pulsed in WAIT_TRIG -> no effect.
  - arm in DONE -> capture_done drops next cycle and wr_addr restarts at 0.
- With WAVE_CAP_AUTO_TRIG_EN, AUTO_TIMEOUT=20, constant input 0x40 -> forced trigger 20 cycles after WAIT_TRIG entry; auto_trig=1 together with capture_done.
